// File: rtl/digit_sprite_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : digit_sprite_ctrl_if
// Description : Pixel-scan, sprite-config and ROM/colour-alignment bus for the
//               digit sprite controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface digit_sprite_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic              frame_start;
    logic              cfg_we;
    logic [1:0]        cfg_slot;
    logic [10:0]       cfg_x;
    logic [9:0]        cfg_y;
    logic [3:0]        cfg_digit;
    logic              cfg_en;
    logic              cfg_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_digit;
    logic              pix_valid;
    logic [1:0]        pix_slot;

    modport master (
        output hcount, vcount, frame_start,
        output cfg_we, cfg_slot, cfg_x, cfg_y, cfg_digit, cfg_en,
        input  cfg_err, rom_addr, rom_digit, pix_valid, pix_slot
    );

    modport slave (
        input  hcount, vcount, frame_start,
        input  cfg_we, cfg_slot, cfg_x, cfg_y, cfg_digit, cfg_en,
        output cfg_err, rom_addr, rom_digit, pix_valid, pix_slot
    );
endinterface
`default_nettype wire

// File: rtl/digit_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_sprite_ctrl
// Description : Per-pixel slot arbitration, shared digit-ROM addressing and
//               frame-committed sprite configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_sprite_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int WIDTH     = 150,
    parameter int HEIGHT    = 150,
    parameter int ADDR_W    = 17,
    parameter int PIPE      = 4
) (
    input  wire logic          pixel_clk,
    input  wire logic          reset,
    digit_sprite_ctrl_if.slave bus
);

    typedef struct packed {
        logic        en;
        logic [10:0] x;
        logic [9:0]  y;
        logic [3:0]  digit;
    } slot_t;

    slot_t [NUM_SLOTS-1:0] r_shadow;
    slot_t [NUM_SLOTS-1:0] r_active;
    slot_t [NUM_SLOTS-1:0] w_shadow_nxt;

    logic                  w_cfg_ok;
    logic [NUM_SLOTS-1:0]  w_hit;
    logic                  w_any;
    logic [1:0]            w_win;
    slot_t                 w_win_cfg;
    logic [10:0]           w_dx;
    logic [9:0]            w_dy;
    logic [31:0]           w_addr_full;

    logic                  r_cfg_err;
    logic [ADDR_W-1:0]     r_rom_addr;
    logic [3:0]            r_rom_digit;
    logic [PIPE-1:0]       r_vld_pipe;
    logic [PIPE-1:0][1:0]  r_slot_pipe;

    assign w_cfg_ok = (32'(bus.cfg_slot) < 32'(NUM_SLOTS)) && (bus.cfg_digit <= 4'd9);

    // Writes landing in the commit cycle must be part of the committed set.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (bus.cfg_we && w_cfg_ok) begin
            w_shadow_nxt[bus.cfg_slot] = {bus.cfg_en, bus.cfg_x, bus.cfg_y, bus.cfg_digit};
        end
    end

    // Upper bounds widened by one bit so sprites near the right/bottom edge clip instead of wrapping.
    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
            assign w_hit[g] = r_active[g].en
                && (bus.hcount >= r_active[g].x)
                && (12'(bus.hcount) < (12'(r_active[g].x) + 12'(WIDTH)))
                && (bus.vcount >= r_active[g].y)
                && (11'(bus.vcount) < (11'(r_active[g].y) + 11'(HEIGHT)));
        end
    endgenerate

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any = 1'b1;
                w_win = 2'(i);
            end
        end
    end

    assign w_win_cfg   = r_active[w_win];
    assign w_dx        = bus.hcount - w_win_cfg.x;
    assign w_dy        = bus.vcount - w_win_cfg.y;
    assign w_addr_full = 32'(w_dx) + (32'(w_dy) * 32'(WIDTH));

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_cfg_err   <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_digit <= '0;
            r_vld_pipe  <= '0;
            r_slot_pipe <= '0;
        end else begin
            r_shadow  <= w_shadow_nxt;
            if (bus.frame_start) begin
                r_active <= w_shadow_nxt;
            end
            r_cfg_err   <= bus.cfg_we && !w_cfg_ok;
            r_rom_addr  <= w_any ? ADDR_W'(w_addr_full) : '0;
            r_rom_digit <= w_any ? w_win_cfg.digit : 4'd0;
            r_vld_pipe  <= {r_vld_pipe[PIPE-2:0], w_any};
            r_slot_pipe <= {r_slot_pipe[PIPE-2:0], w_win};
        end
    end

    assign bus.cfg_err   = r_cfg_err;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.rom_digit = r_rom_digit;
    assign bus.pix_valid = r_vld_pipe[PIPE-1];
    assign bus.pix_slot  = r_slot_pipe[PIPE-1];

endmodule
`default_nettype wire

// File: tb/tb_digit_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_sprite_ctrl
// Description : Directed and randomized bench for digit_sprite_ctrl against a
//               behavioural sprite model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_sprite_ctrl;

    localparam int NS = 4;
    localparam int W  = 150;
    localparam int H  = 150;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    digit_sprite_ctrl_if #(.ADDR_W(17)) bus ();

    digit_sprite_ctrl #(
        .NUM_SLOTS(NS), .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .PIPE(4)
    ) dut (
        .pixel_clk(clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef struct {
        bit vld;
        int slot;
        int addr;
        int digit;
    } rec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_on   = 0;

    int   sh_en[NS], sh_x[NS], sh_y[NS], sh_d[NS];
    int   ac_en[NS], ac_x[NS], ac_y[NS], ac_d[NS];
    rec_t hist[$];
    rec_t m_rec;
    rec_t m_drop;
    bit   m_err;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic view: first enabled slot whose rectangle covers (h,v).
    function automatic rec_t model_pixel(input int h, input int v);
        rec_t r;
        r.vld = 0; r.slot = 0; r.addr = 0; r.digit = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (ac_en[i] != 0 && h >= ac_x[i] && h < ac_x[i] + W &&
                v >= ac_y[i] && v < ac_y[i] + H) begin
                r.vld   = 1;
                r.slot  = i;
                r.addr  = ((h - ac_x[i]) + (v - ac_y[i]) * W) % (1 << 17);
                r.digit = ac_d[i];
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        rec_t z;
        z.vld = 0; z.slot = 0; z.addr = 0; z.digit = 0;
        for (int i = 0; i < NS; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_d[i] = 0;
            ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_d[i] = 0;
        end
        hist.delete();
        for (int i = 0; i < 4; i++) hist.push_back(z);
        m_err = 0;
    endtask

    initial model_clear();

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else begin
            m_rec = model_pixel(int'(bus.hcount), int'(bus.vcount));
            hist.push_back(m_rec);
            m_drop = hist.pop_front();
            m_err = bus.cfg_we && (bus.cfg_digit > 4'd9);
            if (bus.cfg_we && bus.cfg_digit <= 4'd9) begin
                sh_en[bus.cfg_slot] = int'(bus.cfg_en);
                sh_x[bus.cfg_slot]  = int'(bus.cfg_x);
                sh_y[bus.cfg_slot]  = int'(bus.cfg_y);
                sh_d[bus.cfg_slot]  = int'(bus.cfg_digit);
            end
            if (bus.frame_start) begin
                ac_en = sh_en; ac_x = sh_x; ac_y = sh_y; ac_d = sh_d;
            end
        end
    end

    // Every-cycle comparison: rom outputs track the newest sample, pixel tag the oldest.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_rom_addr",  int'(bus.rom_addr),  hist[3].addr);
            check("cyc_rom_digit", int'(bus.rom_digit), hist[3].digit);
            check("cyc_pix_valid", int'(bus.pix_valid), int'(hist[0].vld));
            if (hist[0].vld) check("cyc_pix_slot", int'(bus.pix_slot), hist[0].slot);
            check("cyc_cfg_err",   int'(bus.cfg_err),   int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int slot, input int x, input int y, input int d,
                             input bit en, input bit fs);
        bus.cfg_we      = 1'b1;
        bus.cfg_slot    = 2'(slot);
        bus.cfg_x       = 11'(x);
        bus.cfg_y       = 10'(y);
        bus.cfg_digit   = 4'(d);
        bus.cfg_en      = en;
        bus.frame_start = fs;
        tick();
        bus.cfg_we      = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic commit();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic scan(input string name, input int h, input int v, input int e_addr,
                        input int e_digit, input bit e_vld, input int e_slot);
        bus.hcount = 11'(h);
        bus.vcount = 10'(v);
        tick();
        check({name, "_addr"},  int'(bus.rom_addr),  e_addr);
        check({name, "_digit"}, int'(bus.rom_digit), e_digit);
        tick(); tick(); tick();
        check({name, "_valid"}, int'(bus.pix_valid), int'(e_vld));
        if (e_vld) check({name, "_slot"}, int'(bus.pix_slot), e_slot);
    endtask

    initial begin
        bus.hcount = '0; bus.vcount = '0; bus.frame_start = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_slot = '0; bus.cfg_x = '0; bus.cfg_y = '0;
        bus.cfg_digit = '0; bus.cfg_en = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check("rst_addr",  int'(bus.rom_addr),  0);
        check("rst_valid", int'(bus.pix_valid), 0);
        check("rst_err",   int'(bus.cfg_err),   0);
        chk_on = 1;
        rst = 1'b0;

        cfg_write(0, 100, 50, 4, 1, 0);
        commit();
        scan("s0_origin", 100, 50, 0,   4, 1, 0);
        scan("s0_right",  249, 50, 149, 4, 1, 0);
        scan("s0_past",   250, 50, 0,   0, 0, 0);
        scan("s0_row1",   100, 51, 150, 4, 1, 0);

        cfg_write(1, 0, 0, 7, 1, 0);
        scan("s1_shadow", 10, 10, 0, 0, 0, 0);
        commit();
        scan("s1_commit", 10, 10, 1510, 7, 1, 1);

        cfg_write(0, 100, 100, 2, 1, 0);
        cfg_write(2, 120, 100, 9, 1, 0);
        commit();
        scan("overlap", 130, 100, 30, 2, 1, 0);

        cfg_write(3, 40, 40, 12, 1, 0);
        check("err_pulse", int'(bus.cfg_err), 1);
        tick();
        check("err_clear", int'(bus.cfg_err), 0);
        commit();
        scan("err_noslot3", 900, 700, 0, 0, 0, 0);
        cfg_write(3, 500, 400, 5, 1, 1);
        scan("coincide", 510, 400, 10, 5, 1, 3);

        cfg_write(0, 2000, 0, 3, 1, 0);
        cfg_write(1, 0, 0, 7, 0, 1);
        scan("clip_2047", 2047, 0, 47, 3, 1, 0);
        scan("clip_wrap", 0, 0, 0, 0, 0, 0);

        bus.hcount = 11'd2010; bus.vcount = 10'd0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", int'(bus.pix_valid), 0);
        check("midrst_addr",  int'(bus.rom_addr),  0);
        rst = 1'b0;
        commit();
        scan("midrst_off", 2010, 0, 0, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            bus.cfg_we      = ($urandom_range(0, 3) == 0);
            bus.cfg_slot    = 2'($urandom_range(0, 3));
            bus.cfg_x       = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(1900, 2047))
                                                         : 11'($urandom_range(0, 400));
            bus.cfg_y       = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(900, 1023))
                                                         : 10'($urandom_range(0, 300));
            bus.cfg_digit   = 4'($urandom_range(0, 15));
            bus.cfg_en      = ($urandom_range(0, 4) != 0);
            bus.frame_start = ($urandom_range(0, 19) == 0);
            bus.hcount      = ($urandom_range(0, 3) != 0) ? 11'($urandom_range(0, 600))
                                                         : 11'($urandom_range(0, 2047));
            bus.vcount      = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 450))
                                                         : 10'($urandom_range(0, 1023));
            rst             = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        bus.frame_start = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
